// File: rtl/sc_waypoint_sequencer_if.sv
// Waypoint sequencer control/status bundle: run controls and ack come in from the
// master side, the mux select and run status go back out from the sequencer.
interface sc_waypoint_sequencer_if;
  logic       SC_WAYPOINT_SEQUENCER_start_In;
  logic       SC_WAYPOINT_SEQUENCER_abort_In;
  logic       SC_WAYPOINT_SEQUENCER_loop_In;
  logic [2:0] SC_WAYPOINT_SEQUENCER_lastIndex_InBus;
  logic       SC_WAYPOINT_SEQUENCER_ack_In;
  logic [2:0] SC_WAYPOINT_SEQUENCER_select_OutBus;
  logic       SC_WAYPOINT_SEQUENCER_valid_Out;
  logic       SC_WAYPOINT_SEQUENCER_busy_Out;
  logic       SC_WAYPOINT_SEQUENCER_done_Out;
  logic       SC_WAYPOINT_SEQUENCER_timeout_Out;

  modport master (
    output SC_WAYPOINT_SEQUENCER_start_In, SC_WAYPOINT_SEQUENCER_abort_In,
           SC_WAYPOINT_SEQUENCER_loop_In, SC_WAYPOINT_SEQUENCER_lastIndex_InBus,
           SC_WAYPOINT_SEQUENCER_ack_In,
    input  SC_WAYPOINT_SEQUENCER_select_OutBus, SC_WAYPOINT_SEQUENCER_valid_Out,
           SC_WAYPOINT_SEQUENCER_busy_Out, SC_WAYPOINT_SEQUENCER_done_Out,
           SC_WAYPOINT_SEQUENCER_timeout_Out
  );

  modport slave (
    input  SC_WAYPOINT_SEQUENCER_start_In, SC_WAYPOINT_SEQUENCER_abort_In,
           SC_WAYPOINT_SEQUENCER_loop_In, SC_WAYPOINT_SEQUENCER_lastIndex_InBus,
           SC_WAYPOINT_SEQUENCER_ack_In,
    output SC_WAYPOINT_SEQUENCER_select_OutBus, SC_WAYPOINT_SEQUENCER_valid_Out,
           SC_WAYPOINT_SEQUENCER_busy_Out, SC_WAYPOINT_SEQUENCER_done_Out,
           SC_WAYPOINT_SEQUENCER_timeout_Out
  );
endinterface

// File: rtl/sc_waypoint_sequencer.sv
// Steps an 8:1 waypoint mux through slots 0..lastIndex, presenting each until the
// consumer acks, dwelling afterwards, with optional looping and an ISSUE watchdog.
module sc_waypoint_sequencer #(
  parameter int unsigned DWELL_CYCLES   = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                     SC_WAYPOINT_SEQUENCER_CLOCK_50,
  input  logic                     SC_WAYPOINT_SEQUENCER_RESET_InHigh,
  sc_waypoint_sequencer_if.slave   bus
);

  localparam int unsigned DWELL_EFF   = (DWELL_CYCLES == 0) ? 1 : DWELL_CYCLES;
  localparam int unsigned TIMEOUT_EFF = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
  localparam logic [COUNT_WIDTH-1:0] DWELL_LAST   = COUNT_WIDTH'(DWELL_EFF - 1);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_EFF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_ISSUE, S_DWELL, S_DONE, S_FAULT
  } state_t;

  state_t                 r_state, w_state;
  logic [2:0]             r_index, w_index;
  logic [2:0]             r_last, w_last;
  logic                   r_loop, w_loop;
  logic [COUNT_WIDTH-1:0] r_wd, w_wd;
  logic [COUNT_WIDTH-1:0] r_dw, w_dw;
  logic [2:0]             r_select, w_select;
  logic                   r_valid, w_valid;
  logic                   r_busy, w_busy;
  logic                   r_done, w_done;
  logic                   r_timeout, w_timeout;

  always_ff @(posedge SC_WAYPOINT_SEQUENCER_CLOCK_50) begin
    if (SC_WAYPOINT_SEQUENCER_RESET_InHigh) begin
      r_state   <= S_IDLE;
      r_index   <= 3'd0;
      r_last    <= 3'd0;
      r_loop    <= 1'b0;
      r_wd      <= '0;
      r_dw      <= '0;
      r_select  <= 3'd0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_index   <= w_index;
      r_last    <= w_last;
      r_loop    <= w_loop;
      r_wd      <= w_wd;
      r_dw      <= w_dw;
      r_select  <= w_select;
      r_valid   <= w_valid;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_timeout <= w_timeout;
    end
  end

  // Outputs are computed one state ahead so every port comes straight from a flop.
  always_comb begin
    w_state   = r_state;
    w_index   = r_index;
    w_last    = r_last;
    w_loop    = r_loop;
    w_wd      = r_wd;
    w_dw      = r_dw;
    w_select  = r_select;
    w_valid   = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_timeout = r_timeout;

    if (bus.SC_WAYPOINT_SEQUENCER_abort_In) begin
      w_state  = S_IDLE;
      w_index  = 3'd0;
      w_select = 3'd0;
    end else begin
      case (r_state)
        S_IDLE, S_FAULT: begin
          if (bus.SC_WAYPOINT_SEQUENCER_start_In) begin
            w_state   = S_SETTLE;
            w_index   = 3'd0;
            w_select  = 3'd0;
            w_busy    = 1'b1;
            w_last    = bus.SC_WAYPOINT_SEQUENCER_lastIndex_InBus;
            w_loop    = bus.SC_WAYPOINT_SEQUENCER_loop_In;
            w_timeout = 1'b0;
          end
        end
        S_SETTLE: begin
          w_state = S_ISSUE;
          w_valid = 1'b1;
          w_busy  = 1'b1;
          w_wd    = '0;
        end
        S_ISSUE: begin
          w_busy = 1'b1;
          // An ack landing on the expiry cycle still counts as success.
          if (bus.SC_WAYPOINT_SEQUENCER_ack_In) begin
            w_state = S_DWELL;
            w_dw    = '0;
          end else if (r_wd == TIMEOUT_LAST) begin
            w_state   = S_FAULT;
            w_busy    = 1'b0;
            w_timeout = 1'b1;
          end else begin
            w_valid = 1'b1;
            w_wd    = r_wd + COUNT_WIDTH'(1);
          end
        end
        S_DWELL: begin
          w_busy = 1'b1;
          if (r_dw == DWELL_LAST) begin
            if (r_index != r_last) begin
              w_state  = S_SETTLE;
              w_index  = r_index + 3'd1;
              w_select = r_index + 3'd1;
            end else if (r_loop) begin
              w_state  = S_SETTLE;
              w_index  = 3'd0;
              w_select = 3'd0;
            end else begin
              w_state = S_DONE;
              w_busy  = 1'b0;
              w_done  = 1'b1;
            end
          end else begin
            w_dw = r_dw + COUNT_WIDTH'(1);
          end
        end
        S_DONE: begin
          w_state = S_IDLE;
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  assign bus.SC_WAYPOINT_SEQUENCER_select_OutBus = r_select;
  assign bus.SC_WAYPOINT_SEQUENCER_valid_Out     = r_valid;
  assign bus.SC_WAYPOINT_SEQUENCER_busy_Out      = r_busy;
  assign bus.SC_WAYPOINT_SEQUENCER_done_Out      = r_done;
  assign bus.SC_WAYPOINT_SEQUENCER_timeout_Out   = r_timeout;

endmodule

// File: tb/tb_sc_waypoint_sequencer.sv
// Directed bench for sc_waypoint_sequencer with DWELL_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_sc_waypoint_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sc_waypoint_sequencer_if bus();

  sc_waypoint_sequencer #(
    .DWELL_CYCLES(4),
    .TIMEOUT_CYCLES(20),
    .COUNT_WIDTH(32)
  ) dut (
    .SC_WAYPOINT_SEQUENCER_CLOCK_50(clk),
    .SC_WAYPOINT_SEQUENCER_RESET_InHigh(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [2:0] sel;
  logic       vld, bsy, dn, tmo;
  assign sel = bus.SC_WAYPOINT_SEQUENCER_select_OutBus;
  assign vld = bus.SC_WAYPOINT_SEQUENCER_valid_Out;
  assign bsy = bus.SC_WAYPOINT_SEQUENCER_busy_Out;
  assign dn  = bus.SC_WAYPOINT_SEQUENCER_done_Out;
  assign tmo = bus.SC_WAYPOINT_SEQUENCER_timeout_Out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic st, input logic ab, input logic lp,
                        input logic [2:0] li, input logic ak);
    bus.SC_WAYPOINT_SEQUENCER_start_In     = st;
    bus.SC_WAYPOINT_SEQUENCER_abort_In     = ab;
    bus.SC_WAYPOINT_SEQUENCER_loop_In      = lp;
    bus.SC_WAYPOINT_SEQUENCER_lastIndex_InBus = li;
    bus.SC_WAYPOINT_SEQUENCER_ack_In       = ak;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b1, 1'b0, 1'b1, 3'd5, 1'b1);
    tick();
    tick();
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_select got %0d expected 0", sel); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b expected 0", vld); end
    checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", bsy); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL reset_done got %0b expected 0", dn); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b expected 0", tmo); end
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    tick();
  endtask

  // lastIndex=2, loop=0, ack 3 cycles after each valid rise; lastIndex is changed mid-run.
  task automatic test_walk();
    int done_cnt;
    done_cnt = 0;
    set_in(1'b1, 1'b0, 1'b0, 3'd2, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (sel !== 3'(i)) begin errors++; $display("FAIL walk_settle_select got %0d expected %0d", sel, i); end
      checks++; if (vld !== 1'b0 || bsy !== 1'b1) begin errors++; $display("FAIL walk_settle_vb got %0b%0b expected 01", vld, bsy); end
      tick();
      checks++; if (vld !== 1'b1 || sel !== 3'(i)) begin errors++; $display("FAIL walk_issue got valid %0b select %0d expected 1 %0d", vld, sel, i); end
      tick();
      tick();
      checks++; if (vld !== 1'b1 || sel !== 3'(i)) begin errors++; $display("FAIL walk_hold got valid %0b select %0d expected 1 %0d", vld, sel, i); end
      bus.SC_WAYPOINT_SEQUENCER_ack_In = 1'b1;
      tick();
      bus.SC_WAYPOINT_SEQUENCER_ack_In = 1'b0;
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (vld !== 1'b0 || bsy !== 1'b1 || sel !== 3'(i)) begin
          errors++; $display("FAIL walk_dwell%0d got valid %0b busy %0b select %0d expected 0 1 %0d", d, vld, bsy, sel, i);
        end
        if (d < 3) tick();
      end
      tick();
      if (dn === 1'b1) done_cnt++;
    end
    checks++; if (dn !== 1'b1 || bsy !== 1'b0) begin errors++; $display("FAIL walk_done got done %0b busy %0b expected 1 0", dn, bsy); end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (dn === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL walk_done_count got %0d expected 1", done_cnt); end
    checks++; if (bsy !== 1'b0 || vld !== 1'b0) begin errors++; $display("FAIL walk_after got busy %0b valid %0b expected 0 0", bsy, vld); end
  endtask

  // lastIndex=7, loop=1, immediate acks; loop is dropped mid-run and must be ignored.
  task automatic test_loop();
    int bad_busy, done_seen;
    bad_busy = 0;
    done_seen = 0;
    set_in(1'b1, 1'b0, 1'b1, 3'd7, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (vld !== 1'b1 || sel !== 3'(k % 8)) begin
        errors++; $display("FAIL loop_issue%0d got valid %0b select %0d expected 1 %0d", k, vld, sel, k % 8);
      end
      bus.SC_WAYPOINT_SEQUENCER_ack_In = 1'b1;
      tick();
      bus.SC_WAYPOINT_SEQUENCER_ack_In = 1'b0;
      if (bsy !== 1'b1) bad_busy++;
      if (dn !== 1'b0) done_seen++;
      for (int d = 0; d < 4; d++) begin
        tick();
        if (bsy !== 1'b1) bad_busy++;
        if (dn !== 1'b0) done_seen++;
      end
    end
    checks++; if (bad_busy !== 0) begin errors++; $display("FAIL loop_busy got %0d drops expected 0", bad_busy); end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL loop_done got %0d pulses expected 0", done_seen); end
    bus.SC_WAYPOINT_SEQUENCER_abort_In = 1'b1;
    tick();
    bus.SC_WAYPOINT_SEQUENCER_abort_In = 1'b0;
    checks++; if (bsy !== 1'b0 || vld !== 1'b0 || sel !== 3'd0) begin errors++; $display("FAIL loop_abort got busy %0b valid %0b select %0d expected 0 0 0", bsy, vld, sel); end
    tick();
  endtask

  // Ack withheld: fault after 20 ISSUE cycles, restart from FAULT, ack on the expiry cycle.
  task automatic test_timeout();
    set_in(1'b1, 1'b0, 1'b0, 3'd1, 1'b0);
    tick();
    bus.SC_WAYPOINT_SEQUENCER_start_In = 1'b0;
    tick();
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL to_rise got valid %0b expected 1", vld); end
    repeat (19) tick();
    checks++; if (vld !== 1'b1 || tmo !== 1'b0) begin errors++; $display("FAIL to_pre got valid %0b timeout %0b expected 1 0", vld, tmo); end
    tick();
    checks++; if (tmo !== 1'b1 || vld !== 1'b0 || bsy !== 1'b0) begin errors++; $display("FAIL to_fault got timeout %0b valid %0b busy %0b expected 1 0 0", tmo, vld, bsy); end
    bus.SC_WAYPOINT_SEQUENCER_ack_In = 1'b1;
    repeat (3) tick();
    bus.SC_WAYPOINT_SEQUENCER_ack_In = 1'b0;
    checks++; if (tmo !== 1'b1 || bsy !== 1'b0 || vld !== 1'b0) begin errors++; $display("FAIL to_sticky got timeout %0b busy %0b valid %0b expected 1 0 0", tmo, bsy, vld); end
    bus.SC_WAYPOINT_SEQUENCER_start_In = 1'b1;
    tick();
    bus.SC_WAYPOINT_SEQUENCER_start_In = 1'b0;
    checks++; if (tmo !== 1'b0 || sel !== 3'd0 || vld !== 1'b0 || bsy !== 1'b1) begin errors++; $display("FAIL to_restart got timeout %0b select %0d valid %0b busy %0b expected 0 0 0 1", tmo, sel, vld, bsy); end
    tick();
    checks++; if (vld !== 1'b1 || sel !== 3'd0) begin errors++; $display("FAIL to_restart_issue got valid %0b select %0d expected 1 0", vld, sel); end
    repeat (19) tick();
    bus.SC_WAYPOINT_SEQUENCER_ack_In = 1'b1;
    tick();
    bus.SC_WAYPOINT_SEQUENCER_ack_In = 1'b0;
    checks++; if (tmo !== 1'b0 || bsy !== 1'b1 || vld !== 1'b0) begin errors++; $display("FAIL to_ack_wins got timeout %0b busy %0b valid %0b expected 0 1 0", tmo, bsy, vld); end
    bus.SC_WAYPOINT_SEQUENCER_abort_In = 1'b1;
    tick();
    bus.SC_WAYPOINT_SEQUENCER_abort_In = 1'b0;
    // Second fault, then abort must keep the flag while reset clears it.
    bus.SC_WAYPOINT_SEQUENCER_start_In = 1'b1;
    tick();
    bus.SC_WAYPOINT_SEQUENCER_start_In = 1'b0;
    repeat (21) tick();
    bus.SC_WAYPOINT_SEQUENCER_abort_In = 1'b1;
    tick();
    bus.SC_WAYPOINT_SEQUENCER_abort_In = 1'b0;
    checks++; if (tmo !== 1'b1 || bsy !== 1'b0) begin errors++; $display("FAIL to_abort_keep got timeout %0b busy %0b expected 1 0", tmo, bsy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL to_reset_clear got %0b expected 0", tmo); end
  endtask

  // Start while busy is ignored; abort beats a simultaneous ack.
  task automatic test_abort();
    set_in(1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
    tick();
    bus.SC_WAYPOINT_SEQUENCER_start_In = 1'b0;
    tick();
    bus.SC_WAYPOINT_SEQUENCER_ack_In = 1'b1;
    tick();
    bus.SC_WAYPOINT_SEQUENCER_ack_In = 1'b0;
    bus.SC_WAYPOINT_SEQUENCER_start_In = 1'b1;
    tick();
    bus.SC_WAYPOINT_SEQUENCER_start_In = 1'b0;
    checks++; if (bsy !== 1'b1 || vld !== 1'b0 || sel !== 3'd0) begin errors++; $display("FAIL ab_start_busy got busy %0b valid %0b select %0d expected 1 0 0", bsy, vld, sel); end
    repeat (3) tick();
    checks++; if (sel !== 3'd1 || vld !== 1'b0) begin errors++; $display("FAIL ab_settle1 got select %0d valid %0b expected 1 0", sel, vld); end
    tick();
    checks++; if (sel !== 3'd1 || vld !== 1'b1) begin errors++; $display("FAIL ab_issue1 got select %0d valid %0b expected 1 1", sel, vld); end
    bus.SC_WAYPOINT_SEQUENCER_abort_In = 1'b1;
    bus.SC_WAYPOINT_SEQUENCER_ack_In = 1'b1;
    tick();
    bus.SC_WAYPOINT_SEQUENCER_abort_In = 1'b0;
    bus.SC_WAYPOINT_SEQUENCER_ack_In = 1'b0;
    checks++; if (vld !== 1'b0 || sel !== 3'd0 || bsy !== 1'b0 || dn !== 1'b0) begin errors++; $display("FAIL ab_idle got valid %0b select %0d busy %0b done %0b expected 0 0 0 0", vld, sel, bsy, dn); end
    repeat (6) tick();
    checks++; if (dn !== 1'b0 || bsy !== 1'b0) begin errors++; $display("FAIL ab_stays_idle got done %0b busy %0b expected 0 0", dn, bsy); end
  endtask

  // Reset while dwelling on slot 3, then a fresh run starts at slot 0.
  task automatic test_reset_mid();
    set_in(1'b1, 1'b0, 1'b0, 3'd5, 1'b0);
    tick();
    bus.SC_WAYPOINT_SEQUENCER_start_In = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.SC_WAYPOINT_SEQUENCER_ack_In = 1'b1;
      tick();
      bus.SC_WAYPOINT_SEQUENCER_ack_In = 1'b0;
      if (k < 3) repeat (4) tick();
    end
    tick();
    checks++; if (sel !== 3'd3 || bsy !== 1'b1 || vld !== 1'b0) begin errors++; $display("FAIL rm_dwell3 got select %0d busy %0b valid %0b expected 3 1 0", sel, bsy, vld); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (sel !== 3'd0 || vld !== 1'b0 || bsy !== 1'b0 || dn !== 1'b0 || tmo !== 1'b0) begin errors++; $display("FAIL rm_reset got select %0d valid %0b busy %0b done %0b timeout %0b expected all 0", sel, vld, bsy, dn, tmo); end
    repeat (6) tick();
    checks++; if (dn !== 1'b0 || bsy !== 1'b0) begin errors++; $display("FAIL rm_no_done got done %0b busy %0b expected 0 0", dn, bsy); end
    bus.SC_WAYPOINT_SEQUENCER_start_In = 1'b1;
    tick();
    bus.SC_WAYPOINT_SEQUENCER_start_In = 1'b0;
    tick();
    checks++; if (sel !== 3'd0 || vld !== 1'b1) begin errors++; $display("FAIL rm_restart got select %0d valid %0b expected 0 1", sel, vld); end
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    test_reset();
    test_walk();
    test_loop();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sc_waypoint_sequencer.md
SC_WAYPOINT_SEQUENCER -- requirements
Module: SC_WAYPOINT_SEQUENCER

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 1000: hold cycles after each acknowledged waypoint; 0 is treated as 1.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000: maximum cycles in ISSUE without ack.
REQ-003 SHALL have parameter COUNT_WIDTH, default 32: width of the dwell and watchdog counters.
REQ-004 SHALL have one clock and a synchronous, active-high reset:
- SC_WAYPOINT_SEQUENCER_CLOCK_50  in  1  sole clock, rising edge.
- SC_WAYPOINT_SEQUENCER_RESET_InHigh  in  1  reset.
REQ-005 SHALL have the remaining ports:
- SC_WAYPOINT_SEQUENCER_start_In  in  1  single-cycle run request.
- SC_WAYPOINT_SEQUENCER_abort_In  in  1  cancel the run.
- SC_WAYPOINT_SEQUENCER_loop_In  in  1  restart at slot 0 after the last slot.
- SC_WAYPOINT_SEQUENCER_lastIndex_InBus  in  3  index of the final slot (0-7).
- SC_WAYPOINT_SEQUENCER_ack_In  in  1  consumer reached the presented waypoint.
- SC_WAYPOINT_SEQUENCER_select_OutBus  out  3  drives the 8:1 x/y/z waypoint mux select.
- SC_WAYPOINT_SEQUENCER_valid_Out  out  1  mux output is a valid target.
- SC_WAYPOINT_SEQUENCER_busy_Out  out  1  run in progress.
- SC_WAYPOINT_SEQUENCER_done_Out  out  1  one-cycle run-complete pulse.
- SC_WAYPOINT_SEQUENCER_timeout_Out  out  1  sticky watchdog fault flag.

Function
REQ-006 SHALL implement the states IDLE, SETTLE, ISSUE, DWELL, DONE and FAULT; all outputs SHALL be registered.
REQ-007 In IDLE, start SHALL cause the following on the next cycle:
- go to SETTLE;
- set index=0;
- latch lastIndex and loop;
- clear timeout.
REQ-008 SETTLE SHALL last exactly 1 cycle with valid=0, select=index, then go to ISSUE; the first valid=1 appears 2 cycles after start.
REQ-009 ISSUE SHALL hold valid=1 and select stable until ack, then go to DWELL with valid=0 and the dwell counter cleared.
REQ-010 The watchdog SHALL count cycles spent in ISSUE; reaching TIMEOUT_CYCLES without ack SHALL cause FAULT with timeout=1 and valid=0.
REQ-011 If ack arrives in the same cycle the watchdog expires, ack SHALL win.
REQ-012 DWELL SHALL last max(DWELL_CYCLES,1) cycles, then:
- if index != latched lastIndex: index+1, go to SETTLE;
- else if latched loop=1: index=0, go to SETTLE;
- else go to DONE.
REQ-013 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-014 busy SHALL be 1 in SETTLE, ISSUE and DWELL, and 0 in IDLE, DONE and FAULT.
REQ-015 Index arithmetic SHALL be 3-bit; index never exceeds latched lastIndex, so slot 7 with loop=1 wraps to 0.
REQ-016 ack outside ISSUE SHALL be ignored; start outside IDLE/FAULT SHALL be ignored.
REQ-017 abort in SETTLE/ISSUE/DWELL/DONE/FAULT SHALL force IDLE on the next cycle with valid=0, select=0 and no done pulse; abort SHALL take priority over ack, expiry and start; timeout is retained.
REQ-018 In FAULT, start SHALL behave as in IDLE (REQ-007); otherwise the block SHALL remain in FAULT.
REQ-019 Changes to lastIndex or loop during a run SHALL have no effect until the next start.

Reset
REQ-020 Reset SHALL force the following on the next rising edge, overriding all inputs:
- state=IDLE;
- select=0, valid=0, busy=0, done=0, timeout=0;
- counters=0.
REQ-021 Reset asserted mid-run SHALL abandon the run, with no done pulse.

Verification (DWELL_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-022 lastIndex=2, loop=0, start at cycle 0, ack 3 cycles after each valid rise -> the bench SHALL check:
- select walks 0,1,2, each with valid held until ack;
- 4 dwell cycles follow each ack;
- done pulses exactly once, then busy=0.
REQ-023 lastIndex=7, loop=1, immediate acks -> select runs 7 then 0 (wrap), busy stays 1, done never asserts.
REQ-024 start with ack withheld -> 20 cycles after valid rises, timeout=1, valid=0, FAULT; then a new start -> timeout=0, select=0, valid=1 two cycles later.
REQ-025 abort and ack in the same ISSUE cycle -> next cycle IDLE, valid=0, select=0, no done; start while busy shows no effect.
REQ-026 reset asserted in DWELL at index 3 -> next cycle all outputs 0; a later start begins from select=0.
